// File: rtl/point_add_gen.sv
`default_nettype none
// ============================================================================
//  Module   : point_add_gen
//  Desc     : Affine point adder/doubler for short-Weierstrass curves
//             y^2 = x^3 + a*x + b over GF(P), with busy/done handshake,
//             forced-double mode and one shared mod_mul / mod_inv.
//             Optional PADD_CYCLE_CNT_EN adds a cycle_cnt output.
//  Revision : 1.0  initial release
// ============================================================================

// Bit-serial interleaved modular multiplier: one multiplier bit per cycle.
module padd_mod_mul #(
    parameter int               WIDTH = 256,
    parameter logic [WIDTH-1:0] P     = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod
);
    localparam int             c_CW    = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] c_P_EXT = {1'b0, P};

    logic [WIDTH-1:0] r_a, r_b, r_acc;
    logic [c_CW-1:0]  r_cnt;
    logic             r_busy, r_done;
    logic [WIDTH:0]   w_dbl, w_dbl_m, w_sum, w_sum_m;
    logic [WIDTH-1:0] w_dbl_red, w_step;

    // acc = 2*acc (+a when the current multiplier bit is set), reduced each stage
    always_comb begin
        w_dbl     = {r_acc, 1'b0};
        w_dbl_m   = w_dbl - c_P_EXT;
        w_dbl_red = (w_dbl >= c_P_EXT) ? w_dbl_m[WIDTH-1:0] : w_dbl[WIDTH-1:0];
        w_sum     = {1'b0, w_dbl_red} + (r_b[WIDTH-1] ? {1'b0, r_a} : '0);
        w_sum_m   = w_sum - c_P_EXT;
        w_step    = (w_sum >= c_P_EXT) ? w_sum_m[WIDTH-1:0] : w_sum[WIDTH-1:0];
    end

    // operand capture, MSB-first iteration and one-cycle done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_a    <= a;
                r_b    <= b;
                r_acc  <= '0;
                r_cnt  <= c_CW'(WIDTH);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_acc <= w_step;
                r_b   <= r_b << 1;
                r_cnt <= r_cnt - c_CW'(1);
                if (r_cnt == c_CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign prod = r_acc;
endmodule

// Binary extended-Euclid modular inverse; invariants x1*a=u, x2*a=v (mod P).
module padd_mod_inv #(
    parameter int               WIDTH = 256,
    parameter logic [WIDTH-1:0] P     = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    output logic             done,
    output logic [WIDTH-1:0] res
);
    localparam logic [WIDTH:0] c_P_EXT = {1'b0, P};

    logic [WIDTH-1:0] r_u, r_v, r_x1, r_x2, r_res;
    logic             r_busy, r_done;

    function automatic logic [WIDTH-1:0] half(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] s;
        s = {1'b0, x} + (x[0] ? c_P_EXT : '0);
        return s[WIDTH:1];
    endfunction

    function automatic logic [WIDTH-1:0] msub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[WIDTH])
            d = d + c_P_EXT;
        return d[WIDTH-1:0];
    endfunction

    // one halving or one subtraction per cycle until u or v reaches 1 (0 input yields 0)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_u    <= '0;
            r_v    <= '0;
            r_x1   <= '0;
            r_x2   <= '0;
            r_res  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_u    <= a;
                r_v    <= P;
                r_x1   <= WIDTH'(1);
                r_x2   <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (r_u == '0 || r_u == WIDTH'(1) || r_v == WIDTH'(1)) begin
                    r_res  <= (r_u == '0) ? '0 : ((r_u == WIDTH'(1)) ? r_x1 : r_x2);
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else if (!r_u[0]) begin
                    r_u  <= r_u >> 1;
                    r_x1 <= half(r_x1);
                end else if (!r_v[0]) begin
                    r_v  <= r_v >> 1;
                    r_x2 <= half(r_x2);
                end else if (r_u >= r_v) begin
                    r_u  <= r_u - r_v;
                    r_x1 <= msub(r_x1, r_x2);
                end else begin
                    r_v  <= r_v - r_u;
                    r_x2 <= msub(r_x2, r_x1);
                end
            end
        end
    end

    assign done = r_done;
    assign res  = r_res;
endmodule

module point_add_gen #(
    parameter int               WIDTH   = 256,
    parameter logic [WIDTH-1:0] P       = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
    parameter logic [WIDTH-1:0] CURVE_A = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dbl_only,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic             inf1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] y2,
    input  logic             inf2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] y3,
    output logic             inf3
`ifdef PADD_CYCLE_CNT_EN
    ,
    output logic [15:0]      cycle_cnt
`endif
);
    localparam logic [WIDTH:0] c_P_EXT = {1'b0, P};

    typedef enum logic [3:0] {
        S_IDLE, S_CLASSIFY, S_DISPATCH, S_SQ, S_DBL_NUM, S_INV,
        S_LAM, S_LAM_SQ, S_X3, S_YMUL, S_Y3, S_DONE
    } state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_x1, r_y1, r_x2, r_y2;
    logic             r_inf1, r_inf2, r_is_neg, r_is_dbl;
    logic [WIDTH-1:0] r_num, r_den, r_t, r_lam, r_xr;
    logic [WIDTH-1:0] r_x3, r_y3;
    logic             r_inf3, r_mul_start, r_inv_start;
    logic [WIDTH-1:0] w_mul_a, w_mul_b, w_mul_prod, w_inv_res, w_x3;
    logic             w_mul_done, w_inv_done, w_is_neg, w_is_dbl;
    logic [WIDTH:0]   w_ysum;

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= c_P_EXT)
            s = s - c_P_EXT;
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[WIDTH])
            d = d + c_P_EXT;
        return d[WIDTH-1:0];
    endfunction

    padd_mod_mul #(.WIDTH(WIDTH), .P(P)) u_mul (
        .clk(clk), .rst(rst), .start(r_mul_start),
        .a(w_mul_a), .b(w_mul_b), .done(w_mul_done), .prod(w_mul_prod)
    );

    padd_mod_inv #(.WIDTH(WIDTH), .P(P)) u_inv (
        .clk(clk), .rst(rst), .start(r_inv_start),
        .a(r_den), .done(w_inv_done), .res(w_inv_res)
    );

    // full-width classification and the x3 difference chain
    always_comb begin
        w_ysum   = {1'b0, r_y1} + {1'b0, r_y2};
        w_is_neg = !r_inf1 && !r_inf2 && (r_x1 == r_x2) && (w_ysum == '0 || w_ysum == c_P_EXT);
        w_is_dbl = !r_inf1 && !r_inf2 && (r_x1 == r_x2) && (r_y1 == r_y2) && !w_is_neg;
        w_x3     = mod_sub(mod_sub(r_t, r_x1), r_x2);
    end

    // multiplier operand select; only sampled in the cycle its start strobe is high
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            S_SQ:     begin w_mul_a = r_x1;  w_mul_b = r_x1;  end
            S_LAM:    begin w_mul_a = r_num; w_mul_b = r_t;   end
            S_LAM_SQ: begin w_mul_a = r_lam; w_mul_b = r_lam; end
            S_YMUL:   begin w_mul_a = r_lam; w_mul_b = r_t;   end
            default:  ;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // next-state decode; busy/done decode directly from the registered state
    always_comb begin
        w_next = r_state;
        busy   = (r_state != S_IDLE);
        done   = (r_state == S_DONE);
        case (r_state)
            S_IDLE:     if (start) w_next = S_CLASSIFY;
            S_CLASSIFY: w_next = S_DISPATCH;
            S_DISPATCH: begin
                if (r_inf1 || r_inf2 || r_is_neg) w_next = S_DONE;
                else if (r_is_dbl)                w_next = S_SQ;
                else                              w_next = S_INV;
            end
            S_SQ:       if (w_mul_done) w_next = S_DBL_NUM;
            S_DBL_NUM:  w_next = S_INV;
            S_INV:      if (w_inv_done) w_next = S_LAM;
            S_LAM:      if (w_mul_done) w_next = S_LAM_SQ;
            S_LAM_SQ:   if (w_mul_done) w_next = S_X3;
            S_X3:       w_next = S_YMUL;
            S_YMUL:     if (w_mul_done) w_next = S_Y3;
            S_Y3:       w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // one-cycle sub-unit start strobes on entry to a waiting state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_start <= 1'b0;
            r_inv_start <= 1'b0;
        end else begin
            r_mul_start <= (w_next != r_state) && (w_next inside {S_SQ, S_LAM, S_LAM_SQ, S_YMUL});
            r_inv_start <= (w_next != r_state) && (w_next == S_INV);
        end
    end

    // operand latch, intermediate values and held result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x1 <= '0; r_y1 <= '0; r_inf1 <= 1'b0;
            r_x2 <= '0; r_y2 <= '0; r_inf2 <= 1'b0;
            r_is_neg <= 1'b0; r_is_dbl <= 1'b0;
            r_num <= '0; r_den <= '0; r_t <= '0; r_lam <= '0; r_xr <= '0;
            r_x3 <= '0; r_y3 <= '0; r_inf3 <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_x1   <= x1;
                    r_y1   <= y1;
                    r_inf1 <= inf1;
                    r_x2   <= dbl_only ? x1   : x2;
                    r_y2   <= dbl_only ? y1   : y2;
                    r_inf2 <= dbl_only ? inf1 : inf2;
                end
                S_CLASSIFY: begin
                    r_is_neg <= w_is_neg;
                    r_is_dbl <= w_is_dbl;
                end
                S_DISPATCH: begin
                    if (r_inf1) begin
                        r_x3   <= r_inf2 ? '0 : r_x2;
                        r_y3   <= r_inf2 ? '0 : r_y2;
                        r_inf3 <= r_inf2;
                    end else if (r_inf2) begin
                        r_x3   <= r_x1;
                        r_y3   <= r_y1;
                        r_inf3 <= 1'b0;
                    end else if (r_is_neg) begin
                        r_x3   <= '0;
                        r_y3   <= '0;
                        r_inf3 <= 1'b1;
                    end else if (!r_is_dbl) begin
                        r_num <= mod_sub(r_y2, r_y1);
                        r_den <= mod_sub(r_x2, r_x1);
                    end
                end
                S_SQ:      if (w_mul_done) r_t <= w_mul_prod;
                S_DBL_NUM: begin
                    r_num <= mod_add(mod_add(mod_add(r_t, r_t), r_t), CURVE_A);
                    r_den <= mod_add(r_y1, r_y1);
                end
                S_INV:     if (w_inv_done) r_t <= w_inv_res;
                S_LAM:     if (w_mul_done) r_lam <= w_mul_prod;
                S_LAM_SQ:  if (w_mul_done) r_t <= w_mul_prod;
                S_X3: begin
                    r_xr <= w_x3;
                    r_t  <= mod_sub(r_x1, w_x3);
                end
                S_YMUL:    if (w_mul_done) r_t <= w_mul_prod;
                S_Y3: begin
                    r_x3   <= r_xr;
                    r_y3   <= mod_sub(r_t, r_y1);
                    r_inf3 <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign x3   = r_x3;
    assign y3   = r_y3;
    assign inf3 = r_inf3;

`ifdef PADD_CYCLE_CNT_EN
    logic [15:0] r_run, r_cycle_cnt;

    // saturating accept-to-done cycle count, published when done asserts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run       <= '0;
            r_cycle_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && start)
                r_run <= 16'd1;
            else if (r_state != S_IDLE && r_run != 16'hFFFF)
                r_run <= r_run + 16'd1;
            if (w_next == S_DONE && r_state != S_DONE)
                r_cycle_cnt <= (r_run == 16'hFFFF) ? 16'hFFFF : r_run + 16'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_point_add_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_point_add_gen
//  Desc     : Directed self-checking bench for point_add_gen: a small curve
//             (P=97, a=2, b=3) and secp256k1 at default parameters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_point_add_gen;
    localparam logic [255:0] c_GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] c_GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [255:0] c_G2X = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    localparam logic [255:0] c_G2Y = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
    localparam logic [255:0] c_G3X = 256'hF9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9;
    localparam logic [255:0] c_G3Y = 256'h388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672;
    localparam int           c_LIMIT = 20000;

    logic clk, rst;
    // small-curve instance signals
    logic       s_start, s_dbl, s_inf1, s_inf2, s_busy, s_done, s_inf3;
    logic [7:0] s_x1, s_y1, s_x2, s_y2, s_x3, s_y3;
    // secp256k1 instance signals
    logic         b_start, b_dbl, b_inf1, b_inf2, b_busy, b_done, b_inf3;
    logic [255:0] b_x1, b_y1, b_x2, b_y2, b_x3, b_y3;

    int n_checks = 0;
    int n_fail   = 0;

    point_add_gen #(.WIDTH(8), .P(8'd97), .CURVE_A(8'd2)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .dbl_only(s_dbl),
        .x1(s_x1), .y1(s_y1), .inf1(s_inf1), .x2(s_x2), .y2(s_y2), .inf2(s_inf2),
        .busy(s_busy), .done(s_done), .x3(s_x3), .y3(s_y3), .inf3(s_inf3)
    );

    point_add_gen u_big (
        .clk(clk), .rst(rst), .start(b_start), .dbl_only(b_dbl),
        .x1(b_x1), .y1(b_y1), .inf1(b_inf1), .x2(b_x2), .y2(b_y2), .inf2(b_inf2),
        .busy(b_busy), .done(b_done), .x3(b_x3), .y3(b_y3), .inf3(b_inf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // small-curve reference arithmetic mod 97
    function automatic int msub97(input int a, input int b);
        return ((a - b) % 97 + 97) % 97;
    endfunction

    function automatic int minv97(input int a);
        for (int i = 1; i < 97; i++)
            if ((a * i) % 97 == 1) return i;
        return 0;
    endfunction

    task automatic model_add97(input int ax, input int ay, input int bx, input int by,
                               output int rx, output int ry);
        int lam;
        lam = (msub97(by, ay) * minv97(msub97(bx, ax))) % 97;
        rx  = msub97(msub97((lam * lam) % 97, ax), bx);
        ry  = msub97((lam * msub97(ax, rx)) % 97, ay);
    endtask

    task automatic s_launch(input logic dbl, input logic [7:0] ax, input logic [7:0] ay, input logic ai,
                            input logic [7:0] bx, input logic [7:0] by, input logic bi);
        s_dbl = dbl; s_x1 = ax; s_y1 = ay; s_inf1 = ai; s_x2 = bx; s_y2 = by; s_inf2 = bi;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
    endtask

    task automatic b_launch(input logic dbl, input logic [255:0] ax, input logic [255:0] ay, input logic ai,
                            input logic [255:0] bx, input logic [255:0] by, input logic bi);
        b_dbl = dbl; b_x1 = ax; b_y1 = ay; b_inf1 = ai; b_x2 = bx; b_y2 = by; b_inf2 = bi;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
    endtask

    // cyc is the cycle index with the accept cycle as 0
    task automatic wait_done(input bit big, input string tag, inout int cyc);
        while (!(big ? b_done : s_done) && cyc < c_LIMIT) begin
            tick();
            cyc++;
        end
        chk(tag, big ? b_done : s_done, 1'b1);
    endtask

    initial begin : stim
        int  cyc, mx, my, lhs, rhs;
        bit  saw_done;

        rst = 1'b1;
        s_start = 0; s_dbl = 0; s_x1 = 0; s_y1 = 0; s_inf1 = 0; s_x2 = 0; s_y2 = 0; s_inf2 = 0;
        b_start = 0; b_dbl = 0; b_x1 = 0; b_y1 = 0; b_inf1 = 0; b_x2 = 0; b_y2 = 0; b_inf2 = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_s_busy", s_busy, 0);
        chk("rst_s_done", s_done, 0);
        chk("rst_s_out", {s_inf3, s_x3, s_y3}, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_done", b_done, 0);
        chk("rst_b_out", {b_inf3, b_x3, b_y3}, 0);

        // small curve: forced double of (3,6), Q inputs are junk and must be ignored
        s_launch(1'b1, 8'd3, 8'd6, 1'b0, 8'd55, 8'd44, 1'b1);
        cyc = 1;
        wait_done(1'b0, "s_dbl_done", cyc);
        chk("s_dbl_x3", s_x3, 80);
        chk("s_dbl_y3", s_y3, 10);
        chk("s_dbl_inf3", s_inf3, 0);
        tick();
        chk("s_dbl_done_once", s_done, 0);
        chk("s_dbl_busy_drop", s_busy, 0);

        // small curve: (3,6)+(80,10) against the bench model, plus on-curve check
        model_add97(3, 6, 80, 10, mx, my);
        s_launch(1'b0, 8'd3, 8'd6, 1'b0, 8'd80, 8'd10, 1'b0);
        cyc = 1;
        wait_done(1'b0, "s_add_done", cyc);
        chk("s_add_x3", s_x3, mx);
        chk("s_add_y3", s_y3, my);
        chk("s_add_inf3", s_inf3, 0);
        lhs = (int'(s_y3) * int'(s_y3)) % 97;
        rhs = (int'(s_x3) * int'(s_x3) * int'(s_x3) + 2 * int'(s_x3) + 3) % 97;
        chk("s_add_on_curve", lhs, rhs);
        tick();

        // small curve: P + (-P) = infinity, special path latency
        s_launch(1'b0, 8'd3, 8'd6, 1'b0, 8'd3, 8'd91, 1'b0);
        cyc = 1;
        chk("s_neg_busy", s_busy, 1);
        wait_done(1'b0, "s_neg_done", cyc);
        chk("s_neg_latency", cyc, 3);
        chk("s_neg_out", {s_inf3, s_x3, s_y3}, {1'b1, 16'h0000});
        tick();

        // small curve: P + infinity = P
        s_launch(1'b0, 8'd3, 8'd6, 1'b0, 8'd9, 8'd9, 1'b1);
        cyc = 1;
        wait_done(1'b0, "s_inf2_done", cyc);
        chk("s_inf2_latency", cyc, 3);
        chk("s_inf2_out", {s_inf3, s_x3, s_y3}, {1'b0, 8'd3, 8'd6});
        tick();

        // secp256k1: G+G through the general doubling path
        b_launch(1'b0, c_GX, c_GY, 1'b0, c_GX, c_GY, 1'b0);
        cyc = 1;
        wait_done(1'b1, "b_gg_done", cyc);
        chk("b_gg_x3", b_x3, c_G2X);
        chk("b_gg_y3", b_y3, c_G2Y);
        chk("b_gg_inf3", b_inf3, 0);
        tick();
        chk("b_gg_done_once", b_done, 0);

        // secp256k1: G+2G with a start pulse while busy; outputs hold until done
        b_launch(1'b0, c_GX, c_GY, 1'b0, c_G2X, c_G2Y, 1'b0);
        cyc = 1;
        repeat (40) begin tick(); cyc++; end
        b_dbl = 1'b1; b_x1 = 256'd1; b_y1 = 256'd2; b_inf1 = 1'b1;
        b_start = 1'b1;
        tick(); cyc++;
        b_start = 1'b0;
        chk("b_busy_mid", b_busy, 1);
        repeat (60) begin tick(); cyc++; end
        chk("b_hold_x3", b_x3, c_G2X);
        chk("b_hold_y3", b_y3, c_G2Y);
        wait_done(1'b1, "b_g3_done", cyc);
        chk("b_g3_x3", b_x3, c_G3X);
        chk("b_g3_y3", b_y3, c_G3Y);
        saw_done = 1'b0;
        repeat (10) begin tick(); if (b_done || b_busy) saw_done = 1'b1; end
        chk("b_ignored_start", saw_done, 0);
        chk("b_post_hold_x3", b_x3, c_G3X);

        // secp256k1: infinity + G = G
        b_launch(1'b0, 256'd5, 256'd7, 1'b1, c_GX, c_GY, 1'b0);
        cyc = 1;
        wait_done(1'b1, "b_inf1_done", cyc);
        chk("b_inf1_latency", cyc, 3);
        chk("b_inf1_out", {b_inf3, b_x3, b_y3}, {1'b0, c_GX, c_GY});
        tick();

        // secp256k1: reset while the inverter is running
        b_launch(1'b0, c_GX, c_GY, 1'b0, c_GX, c_GY, 1'b0);
        repeat (300) tick();
        chk("b_rst_pre_busy", b_busy, 1);
        rst = 1'b1;
        #2;
        chk("b_rst_busy", b_busy, 0);
        chk("b_rst_done", b_done, 0);
        chk("b_rst_out", {b_inf3, b_x3, b_y3}, 0);
        tick();
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (50) begin tick(); if (b_done || b_busy) saw_done = 1'b1; end
        chk("b_rst_no_done", saw_done, 0);

        // fresh forced double after reset, junk Q
        b_launch(1'b1, c_GX, c_GY, 1'b0, 256'd11, 256'd13, 1'b1);
        cyc = 1;
        wait_done(1'b1, "b_fresh_done", cyc);
        chk("b_fresh_x3", b_x3, c_G2X);
        chk("b_fresh_y3", b_y3, c_G2Y);
        chk("b_fresh_inf3", b_inf3, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
